// File: rtl/rvfpm_issue_pkg.sv
// Shared types for the rvfpm issue controller: per-entry lifecycle state and
// the default-width entry record.
package rvfpm_issue_pkg;

    localparam int X_ID_WIDTH_DEF = 4;
    localparam int PAYLOAD_W_DEF  = 32;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        SPEC      = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } entry_state_e;

    typedef struct packed {
        entry_state_e                 state;
        logic [X_ID_WIDTH_DEF-1:0]    id;
        logic [PAYLOAD_W_DEF-1:0]     payload;
    } entry_t;

endpackage

// File: rtl/rvfpm_issue_if.sv
// Issue / commit / dispatch bundle between the core, the issue controller and
// the rvfpm pipeline, plus the occupancy status outputs.
interface rvfpm_issue_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int PAYLOAD_W   = 32
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [PAYLOAD_W-1:0]  issue_payload;
    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [X_ID_WIDTH-1:0] disp_id;
    logic [PAYLOAD_W-1:0]  disp_payload;
    logic                  flush;
    logic                  commit_miss;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      spec_count;

    modport slave (
        input  issue_valid, issue_id, issue_payload,
        input  commit_valid, commit_id, commit_kill,
        input  disp_ready, flush,
        output issue_ready, disp_valid, disp_id, disp_payload,
        output commit_miss, count, spec_count
    );

    modport master (
        output issue_valid, issue_id, issue_payload,
        output commit_valid, commit_id, commit_kill,
        output disp_ready, flush,
        input  issue_ready, disp_valid, disp_id, disp_payload,
        input  commit_miss, count, spec_count
    );

endinterface

// File: rtl/rvfpm_id_match.sv
// Oldest-first search for a SPEC entry whose ID equals key, scanning the
// circular queue starting at head and wrapping modulo the depth.
module rvfpm_id_match #(
    parameter int N     = 4,
    parameter int ID_W  = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]           spec_vec,
    input  logic [N-1:0][ID_W-1:0] ids,
    input  logic [PTR_W-1:0]       head,
    input  logic [ID_W-1:0]        key,
    output logic                   hit,
    output logic [PTR_W-1:0]       idx
);

    logic [PTR_W-1:0] slot;

    // Wrap-aware priority encoder: first match at offset k from head wins.
    always_comb begin
        hit  = 1'b0;
        idx  = head;
        slot = head;
        for (int k = 0; k < N; k++) begin
            slot = head + PTR_W'(k);
            if (!hit && spec_vec[slot] && (ids[slot] == key)) begin
                hit = 1'b1;
                idx = slot;
            end else begin
                hit = hit;
            end
        end
    end

endmodule

// File: rtl/rvfpm_issue_ctrl.sv
// In-order issue buffer: holds speculative FP instructions until resolved,
// dispatches committed ones from the head and silently drops killed ones.
module rvfpm_issue_ctrl
    import rvfpm_issue_pkg::*;
#(
    parameter int X_ID_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int PAYLOAD_W   = 32
) (
    input  logic ck,
    input  logic rst,
    rvfpm_issue_if.slave bus
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_state_e          state_q   [QUEUE_DEPTH];
    entry_state_e          state_d   [QUEUE_DEPTH];
    logic [X_ID_WIDTH-1:0] id_q      [QUEUE_DEPTH];
    logic [X_ID_WIDTH-1:0] id_d      [QUEUE_DEPTH];
    logic [PAYLOAD_W-1:0]  payload_q [QUEUE_DEPTH];
    logic [PAYLOAD_W-1:0]  payload_d [QUEUE_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d, spec_q, spec_d;
    logic                  miss_q, miss_d;

    logic [QUEUE_DEPTH-1:0]                 spec_vec_s;
    logic [QUEUE_DEPTH-1:0][X_ID_WIDTH-1:0] ids_s;
    logic                                   hit_s;
    logic [PTR_W-1:0]                       hit_idx_s;
    logic                                   issue_ready_s, issue_fire_s, pop_s;
    logic                                   new_match_s, spec_inc_s, spec_dec_s;
    entry_state_e                           head_state_s, resolve_state_s;

    // Flatten queue state for the matcher.
    always_comb begin
        spec_vec_s = '0;
        ids_s      = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            spec_vec_s[i] = (state_q[i] == SPEC);
            ids_s[i]      = id_q[i];
        end
    end

    rvfpm_id_match #(
        .N    (QUEUE_DEPTH),
        .ID_W (X_ID_WIDTH),
        .PTR_W(PTR_W)
    ) u_match (
        .spec_vec(spec_vec_s),
        .ids     (ids_s),
        .head    (head_q),
        .key     (bus.commit_id),
        .hit     (hit_s),
        .idx     (hit_idx_s)
    );

    assign head_state_s  = state_q[head_q];
    assign issue_ready_s = (count_q < CNT_W'(QUEUE_DEPTH));

    // Next-state: resolve, pop head, write tail; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        payload_d = payload_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        spec_d    = spec_q;
        miss_d    = 1'b0;

        issue_fire_s    = bus.issue_valid && issue_ready_s;
        pop_s           = (head_state_s == KILLED) ||
                          ((head_state_s == COMMITTED) && bus.disp_ready);
        resolve_state_s = bus.commit_kill ? KILLED : COMMITTED;
        // A same-cycle issue only catches the commit if nothing older matched.
        new_match_s     = bus.commit_valid && !hit_s && issue_fire_s &&
                          (bus.commit_id == bus.issue_id);
        spec_inc_s      = issue_fire_s && !new_match_s;
        spec_dec_s      = bus.commit_valid && hit_s;

        if (bus.flush) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                state_d[i] = EMPTY;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            spec_d  = '0;
        end else begin
            if (spec_dec_s) begin
                state_d[hit_idx_s] = resolve_state_s;
            end else begin
                state_d[hit_idx_s] = state_d[hit_idx_s];
            end
            if (pop_s) begin
                state_d[head_q] = EMPTY;
                head_d          = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            if (issue_fire_s) begin
                state_d[tail_q]   = new_match_s ? resolve_state_s : SPEC;
                id_d[tail_q]      = bus.issue_id;
                payload_d[tail_q] = bus.issue_payload;
                tail_d            = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({issue_fire_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            case ({spec_inc_s, spec_dec_s})
                2'b10:   spec_d = spec_q + CNT_W'(1);
                2'b01:   spec_d = spec_q - CNT_W'(1);
                default: spec_d = spec_q;
            endcase
            miss_d = bus.commit_valid && !hit_s && !new_match_s;
        end
    end

    // Queue state registers with asynchronous reset.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                state_q[i]   <= EMPTY;
                id_q[i]      <= '0;
                payload_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            spec_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            payload_q <= payload_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            spec_q    <= spec_d;
            miss_q    <= miss_d;
        end
    end

    assign bus.issue_ready  = issue_ready_s;
    assign bus.disp_valid   = (head_state_s == COMMITTED);
    assign bus.disp_id      = id_q[head_q];
    assign bus.disp_payload = payload_q[head_q];
    assign bus.commit_miss  = miss_q;
    assign bus.count        = count_q;
    assign bus.spec_count   = spec_q;

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Directed bench for rvfpm_issue_ctrl: ordering, kill drop, full queue,
// same-cycle issue+commit, commit miss, async reset and flush.
module tb_rvfpm_issue_ctrl;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    rvfpm_issue_if #(.X_ID_WIDTH(4), .QUEUE_DEPTH(4), .PAYLOAD_W(32)) bus ();

    rvfpm_issue_ctrl #(.X_ID_WIDTH(4), .QUEUE_DEPTH(4), .PAYLOAD_W(32)) dut (
        .ck (ck),
        .rst(rst),
        .bus(bus)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock, sample 1 time unit after the edge, check invariants.
    task automatic step();
        @(posedge ck);
        #1;
        chk("inv_count_le_depth", 32'(bus.count <= 3'd4), 32'd1);
        chk("inv_spec_le_count", 32'(bus.spec_count <= bus.count), 32'd1);
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_id      = 4'd0;
        bus.issue_payload = 32'd0;
        bus.commit_valid  = 1'b0;
        bus.commit_id     = 4'd0;
        bus.commit_kill   = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic issue(input logic [3:0] id, input logic [31:0] pl);
        bus.issue_valid   = 1'b1;
        bus.issue_id      = id;
        bus.issue_payload = pl;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        bus.commit_valid = 1'b1;
        bus.commit_id    = id;
        bus.commit_kill  = kill;
    endtask

    initial begin
        idle();
        bus.disp_ready = 1'b1;
        repeat (2) @(posedge ck);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_spec", 32'(bus.spec_count), 32'd0);
        chk("rst_ready", 32'(bus.issue_ready), 32'd1);
        chk("rst_dvalid", 32'(bus.disp_valid), 32'd0);
        chk("rst_miss", 32'(bus.commit_miss), 32'd0);
        rst = 1'b0;

        // 1: issue 1,2,3 then commit in order
        issue(4'd1, 32'hA001); step();
        issue(4'd2, 32'hA002); step();
        issue(4'd3, 32'hA003); step();
        idle();
        chk("t1_count3", 32'(bus.count), 32'd3);
        chk("t1_spec3", 32'(bus.spec_count), 32'd3);
        chk("t1_nodisp", 32'(bus.disp_valid), 32'd0);
        commit(4'd1, 1'b0); step();
        chk("t1_dv1", 32'(bus.disp_valid), 32'd1);
        chk("t1_id1", 32'(bus.disp_id), 32'd1);
        chk("t1_pl1", bus.disp_payload, 32'hA001);
        commit(4'd2, 1'b0); step();
        chk("t1_id2", 32'(bus.disp_id), 32'd2);
        chk("t1_pl2", bus.disp_payload, 32'hA002);
        commit(4'd3, 1'b0); step();
        chk("t1_id3", 32'(bus.disp_id), 32'd3);
        chk("t1_dv3", 32'(bus.disp_valid), 32'd1);
        idle(); step();
        chk("t1_count0", 32'(bus.count), 32'd0);
        chk("t1_dv_end", 32'(bus.disp_valid), 32'd0);

        // 2: kill 4, commit 5 and 6
        issue(4'd4, 32'hB004); step();
        issue(4'd5, 32'hB005); step();
        issue(4'd6, 32'hB006); step();
        idle();
        chk("t2_spec3", 32'(bus.spec_count), 32'd3);
        commit(4'd4, 1'b1); step();
        chk("t2_killed_nodisp", 32'(bus.disp_valid), 32'd0);
        chk("t2_spec2", 32'(bus.spec_count), 32'd2);
        commit(4'd5, 1'b0); step();
        chk("t2_count2", 32'(bus.count), 32'd2);
        chk("t2_id5", 32'(bus.disp_id), 32'd5);
        chk("t2_dv5", 32'(bus.disp_valid), 32'd1);
        commit(4'd6, 1'b0); step();
        chk("t2_id6", 32'(bus.disp_id), 32'd6);
        chk("t2_spec0", 32'(bus.spec_count), 32'd0);
        idle(); step();
        chk("t2_count0", 32'(bus.count), 32'd0);

        // 3: fill to depth, fifth issue held until a pop
        bus.disp_ready = 1'b0;
        issue(4'd10, 32'hC00A); step();
        issue(4'd11, 32'hC00B); step();
        issue(4'd12, 32'hC00C); step();
        issue(4'd13, 32'hC00D); step();
        chk("t3_count4", 32'(bus.count), 32'd4);
        chk("t3_spec4", 32'(bus.spec_count), 32'd4);
        chk("t3_notready", 32'(bus.issue_ready), 32'd0);
        issue(4'd14, 32'hC00E); step();
        chk("t3_held", 32'(bus.count), 32'd4);
        commit(4'd10, 1'b0); step();
        chk("t3_full_dv", 32'(bus.disp_valid), 32'd1);
        chk("t3_still_full", 32'(bus.count), 32'd4);
        bus.commit_valid = 1'b0;
        bus.disp_ready   = 1'b1;
        step();
        chk("t3_popped", 32'(bus.count), 32'd3);
        chk("t3_ready", 32'(bus.issue_ready), 32'd1);
        chk("t3_head11", 32'(bus.disp_id), 32'd11);
        step();
        chk("t3_accepted", 32'(bus.count), 32'd4);
        chk("t3_spec4b", 32'(bus.spec_count), 32'd4);
        idle();
        bus.flush = 1'b1; step();
        bus.flush = 1'b0;
        chk("t3_flush_count", 32'(bus.count), 32'd0);
        chk("t3_flush_spec", 32'(bus.spec_count), 32'd0);

        // 4: same-cycle issue and commit of ID 7
        issue(4'd7, 32'hD007);
        commit(4'd7, 1'b0);
        step();
        idle();
        chk("t4_dv", 32'(bus.disp_valid), 32'd1);
        chk("t4_id", 32'(bus.disp_id), 32'd7);
        chk("t4_pl", bus.disp_payload, 32'hD007);
        chk("t4_miss", 32'(bus.commit_miss), 32'd0);
        chk("t4_spec", 32'(bus.spec_count), 32'd0);
        step();
        chk("t4_count0", 32'(bus.count), 32'd0);

        // Duplicate IDs: commit resolves the oldest first
        issue(4'd8, 32'hE001); step();
        issue(4'd8, 32'hE002); step();
        idle();
        commit(4'd8, 1'b0); step();
        chk("dup_pl_old", bus.disp_payload, 32'hE001);
        chk("dup_spec1", 32'(bus.spec_count), 32'd1);
        commit(4'd8, 1'b0); step();
        chk("dup_pl_new", bus.disp_payload, 32'hE002);
        chk("dup_spec0", 32'(bus.spec_count), 32'd0);
        idle(); step();
        chk("dup_count0", 32'(bus.count), 32'd0);

        // 5: commit with empty queue
        commit(4'd9, 1'b0); step();
        idle();
        chk("t5_miss1", 32'(bus.commit_miss), 32'd1);
        chk("t5_count", 32'(bus.count), 32'd0);
        step();
        chk("t5_miss0", 32'(bus.commit_miss), 32'd0);
        chk("t5_spec", 32'(bus.spec_count), 32'd0);

        // 6: asynchronous reset mid-cycle with 3 entries
        bus.disp_ready = 1'b0;
        issue(4'd1, 32'hF001); step();
        issue(4'd2, 32'hF002); step();
        issue(4'd3, 32'hF003); step();
        idle();
        commit(4'd1, 1'b0); step();
        idle();
        chk("t6_pre_dv", 32'(bus.disp_valid), 32'd1);
        chk("t6_pre_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(bus.count), 32'd0);
        chk("t6_rst_dv", 32'(bus.disp_valid), 32'd0);
        chk("t6_rst_ready", 32'(bus.issue_ready), 32'd1);
        chk("t6_rst_spec", 32'(bus.spec_count), 32'd0);
        @(posedge ck);
        #1 rst = 1'b0;

        // 6b: same scenario cleared with flush
        issue(4'd1, 32'hF101); step();
        issue(4'd2, 32'hF102); step();
        issue(4'd3, 32'hF103); step();
        idle();
        commit(4'd1, 1'b0); step();
        idle();
        bus.flush = 1'b1;
        issue(4'd4, 32'hF104);
        commit(4'd2, 1'b0);
        #1;
        chk("t6f_before", 32'(bus.count), 32'd3);
        chk("t6f_dv_before", 32'(bus.disp_valid), 32'd1);
        step();
        idle();
        chk("t6f_count", 32'(bus.count), 32'd0);
        chk("t6f_dv", 32'(bus.disp_valid), 32'd0);
        chk("t6f_ready", 32'(bus.issue_ready), 32'd1);
        chk("t6f_spec", 32'(bus.spec_count), 32'd0);
        chk("t6f_miss", 32'(bus.commit_miss), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
